// File: rtl/branch_target_pipe.sv
// Two-stage branch target generator: extend/shift the offset and pre-add PC_INC in S1,
// then form the target in S2, with a valid/ready handshake on both sides.
module branch_target_pipe #(
    parameter int OFFSET_WIDTH = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int PC_INC       = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic [DATA_WIDTH-1:0]   PC,
    input  logic                    MODE,
    input  logic [1:0]              SHAMT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DATA_WIDTH-1:0]   OUT_IMM,
    output logic [DATA_WIDTH-1:0]   OUT_TARGET
);

    localparam int                    EXT_BITS = DATA_WIDTH - OFFSET_WIDTH;
    localparam logic [DATA_WIDTH-1:0] C_PC_INC = DATA_WIDTH'(PC_INC);

    logic                  w_fill;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_pcinc;
    logic                  w_s2_free;
    logic                  w_s2_load;
    logic                  w_in_xfer;

    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_imm1;
    logic [DATA_WIDTH-1:0] r_pcinc1;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_imm;
    logic [DATA_WIDTH-1:0] r_out_target;

    always_comb begin
        w_fill  = ~MODE & OFFSET[OFFSET_WIDTH-1];
        w_ext   = {{EXT_BITS{w_fill}}, OFFSET};
        w_imm   = w_ext << SHAMT;
        w_pcinc = PC + C_PC_INC;
    end

    // S2 is free when empty or draining this cycle; S1 may refill whenever it empties.
    always_comb begin
        w_s2_free = ~r_out_valid | OUT_READY;
        w_s2_load = r_v1 & w_s2_free;
        IN_READY  = ~RESET & (~r_v1 | w_s2_free);
        w_in_xfer = IN_VALID & IN_READY;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_v1     <= 1'b0;
            r_imm1   <= '0;
            r_pcinc1 <= '0;
        end else if (w_in_xfer) begin
            r_v1     <= 1'b1;
            r_imm1   <= w_imm;
            r_pcinc1 <= w_pcinc;
        end else if (w_s2_load) begin
            r_v1     <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_target <= '0;
        end else if (w_s2_load) begin
            r_out_valid  <= 1'b1;
            r_out_imm    <= r_imm1;
            r_out_target <= r_pcinc1 + r_imm1;
        end else if (OUT_READY) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign OUT_VALID  = r_out_valid;
    assign OUT_IMM    = r_out_imm;
    assign OUT_TARGET = r_out_target;

endmodule

// File: tb/tb_branch_target_pipe.sv
// Bench for branch_target_pipe: directed vectors, backpressure, streaming, random traffic
// and mid-run reset, all scored against an occupancy/FIFO reference model.
module tb_branch_target_pipe;

    logic        clk;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic        MODE;
    logic [1:0]  SHAMT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_IMM;
    logic [31:0] OUT_TARGET;

    branch_target_pipe #(
        .OFFSET_WIDTH(8),
        .DATA_WIDTH  (32),
        .PC_INC      (4)
    ) dut (
        .CLK       (clk),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OFFSET    (OFFSET),
        .PC        (PC),
        .MODE      (MODE),
        .SHAMT     (SHAMT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_IMM   (OUT_IMM),
        .OUT_TARGET(OUT_TARGET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tgt;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   popped   = 0;

    function automatic logic [31:0] ref_imm(logic [7:0] off, logic mode, logic [1:0] sh);
        longint v;
        v = longint'(off);
        if (!mode && off[7]) v = v - 256;
        return 32'(v * (longint'(1) << sh));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at negedge: drive, check against the model, then advance one clock.
    task automatic cycle(input logic iv, input logic [7:0] off, input logic [31:0] pc,
                         input logic mode, input logic [1:0] sh, input logic ordy,
                         input logic rst, output logic accepted);
        logic exp_ov;
        logic exp_rdy;
        exp_t e;
        IN_VALID  = iv;
        OFFSET    = off;
        PC        = pc;
        MODE      = mode;
        SHAMT     = sh;
        OUT_READY = ordy;
        RESET     = rst;
        #1;
        exp_ov  = (q.size() > 0) && (edge_cnt - q[0].acc >= 2);
        exp_rdy = !rst && ((q.size() < 2) || (ordy && exp_ov));
        chk("in_ready", {31'b0, IN_READY}, {31'b0, exp_rdy});
        chk("out_valid", {31'b0, OUT_VALID}, {31'b0, exp_ov});
        if (exp_ov) begin
            chk("out_imm", OUT_IMM, q[0].imm);
            chk("out_target", OUT_TARGET, q[0].tgt);
        end
        @(posedge clk);
        accepted = iv && exp_rdy;
        if (rst) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) begin
                void'(q.pop_front());
                popped++;
            end
            if (accepted) begin
                e.imm = ref_imm(off, mode, sh);
                e.tgt = 32'(pc + 32'd4 + e.imm);
                e.acc = edge_cnt;
                q.push_back(e);
            end
        end
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [7:0] off, input logic [31:0] pc,
                            input logic mode, input logic [1:0] sh,
                            input logic [31:0] exp_imm, input logic [31:0] exp_tgt);
        logic a;
        cycle(1'b1, off, pc, mode, sh, 1'b1, 1'b0, a);
        chk({tag, "_accept"}, {31'b0, a}, 32'd1);
        cycle(1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, a);
        chk({tag, "_valid"}, {31'b0, OUT_VALID}, 32'd1);
        chk({tag, "_imm"}, OUT_IMM, exp_imm);
        chk({tag, "_target"}, OUT_TARGET, exp_tgt);
        cycle(1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, a);
    endtask

    initial begin
        logic        a;
        int          idx;
        int          p0;
        int          n;
        logic [7:0]  bo [4];
        logic [31:0] bp [4];
        logic        bm [4];
        logic [1:0]  bs [4];

        RESET = 1'b1; IN_VALID = 1'b0; OFFSET = '0; PC = '0;
        MODE = 1'b0; SHAMT = '0; OUT_READY = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 8'h12, 32'h40, 1'b0, 2'd1, 1'b1, 1'b1, a);
        chk("reset_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("reset_imm", OUT_IMM, 32'd0);
        chk("reset_target", OUT_TARGET, 32'd0);

        directed("sext_x4", 8'hFE, 32'h100, 1'b0, 2'd2, 32'hFFFF_FFF8, 32'h0000_00FC);
        directed("zext", 8'hFE, 32'h0, 1'b1, 2'd0, 32'h0000_00FE, 32'h0000_0102);
        directed("wrap", 8'h01, 32'hFFFF_FFF8, 1'b0, 2'd2, 32'h0000_0004, 32'h0000_0000);
        directed("sh3_neg", 8'h80, 32'h0, 1'b0, 2'd3, 32'hFFFF_FC00, 32'hFFFF_FC04);

        // Backpressure: four offered inputs while the consumer stalls.
        for (int i = 0; i < 4; i++) begin
            bo[i] = 8'($urandom); bp[i] = $urandom; bm[i] = 1'($urandom); bs[i] = 2'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, bo[idx], bp[idx], bm[idx], bs[idx], 1'b0, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_ready_low", {31'b0, IN_READY}, 32'd0);
        p0 = popped;
        n  = 0;
        while ((idx < 4 || q.size() > 0) && n < 20) begin
            cycle(idx < 4, bo[idx % 4], bp[idx % 4], bm[idx % 4], bs[idx % 4], 1'b1, 1'b0, a);
            if (a) idx++;
            n++;
        end
        chk("bp_drained", 32'(popped - p0), 32'd4);
        chk("bp_no_gaps", 32'(n), 32'd4);

        // Streaming: 16 inputs back to back, then two drain cycles.
        p0 = popped;
        for (int i = 0; i < 18; i++) begin
            cycle(i < 16, 8'($urandom), $urandom, 1'($urandom), 2'($urandom), 1'b1, 1'b0, a);
        end
        chk("stream_count", 32'(popped - p0), 32'd16);
        chk("stream_empty", 32'(q.size()), 32'd0);

        // Random traffic on both handshakes.
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), $urandom, 1'($urandom), 2'($urandom),
                  ($urandom % 3) != 0, 1'b0, a);
        end

        // Fill both stages, then reset mid-flight.
        n = 0;
        while (q.size() < 2 && n < 20) begin
            cycle(1'b1, 8'($urandom), $urandom, 1'($urandom), 2'($urandom), 1'b0, 1'b0, a);
            n++;
        end
        chk("full_before_reset", 32'(q.size()), 32'd2);
        cycle(1'b1, 8'h33, 32'h1234, 1'b0, 2'd0, 1'b0, 1'b1, a);
        chk("flush_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush_imm", OUT_IMM, 32'd0);
        chk("flush_target", OUT_TARGET, 32'd0);
        directed("post_reset", 8'h7F, 32'h2000, 1'b0, 2'd1, 32'h0000_00FE, 32'h0000_2102);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h0, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_target_pipe.md
# branch_target_pipe

Parametrised, pipelined successor to the branch-offset sign-extend/shift-left-2 logic. It accepts a branch offset and the current PC under a valid/ready handshake, and extends the offset (sign or zero, per mode) to the datapath width. It then shifts the offset by a programmable amount and produces both the extended immediate and the branch target `PC + PC_INC + imm`. Two register stages give full throughput with backpressure. The block sits between instruction decode and the PC-select mux.

## Interface
- `OFFSET_WIDTH`, 8: width of the raw offset field (≥2).
- `DATA_WIDTH`, 32: width of PC, immediate and target (> `OFFSET_WIDTH` + 3).
- `PC_INC`, 4: constant added to PC before the offset.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `IN_VALID` input 1: `OFFSET`/`PC`/`MODE`/`SHAMT` are valid this cycle.
- `IN_READY` output 1: block accepts an input this cycle.
- `OFFSET` input `OFFSET_WIDTH`: raw offset.
- `PC` input `DATA_WIDTH`: PC of the branch instruction.
- `MODE` input 1: 0 = sign-extend, 1 = zero-extend.
- `SHAMT` input 2: left-shift amount, 0–3.
- `OUT_VALID` output 1: `OUT_IMM`/`OUT_TARGET` are valid.
- `OUT_READY` input 1: consumer accepts the result this cycle.
- `OUT_IMM` output `DATA_WIDTH`: extended and shifted offset.
- `OUT_TARGET` output `DATA_WIDTH`: `PC + PC_INC + OUT_IMM`, mod 2^`DATA_WIDTH`.

## Operation
- Input handshake: a transfer occurs when `IN_VALID` and `IN_READY` are both high on a rising edge. Output handshake: a transfer occurs when `OUT_VALID` and `OUT_READY` are both high.
- Stage 1 (S1) registers:
  - `imm1 = ext(OFFSET, MODE) << SHAMT`. Extension fills bits `[DATA_WIDTH-1:OFFSET_WIDTH]` with `OFFSET[OFFSET_WIDTH-1]` when `MODE` = 0, or with 0 when `MODE` = 1. The shift discards bits shifted above `DATA_WIDTH-1` and fills vacated LSBs with 0.
  - `pcinc1 = PC + PC_INC`, truncated to `DATA_WIDTH`.
  - `v1`, the S1 valid bit.
- Stage 2 (S2) registers:
  - `OUT_IMM = imm1`.
  - `OUT_TARGET = pcinc1 + imm1`, truncated; carry out is discarded.
  - `OUT_VALID`, the S2 valid bit.
- Advance rules:
  - S2 loads when `v1 && (!OUT_VALID || OUT_READY)`.
  - `OUT_VALID` clears when a transfer occurs and S1 is empty.
  - S1 loads on an input transfer.
  - `v1` clears when S1 moves to S2 and no new input arrives in the same cycle.
- `IN_READY = !RESET && (!v1 || !OUT_VALID || OUT_READY)`. This is combinational, with no dependence on `IN_VALID`.
- Simultaneous events: an input transfer, an S1→S2 move and an output transfer can all occur in the same cycle, giving one result per cycle in steady state.
- While stalled (`OUT_VALID` high, `OUT_READY` low), `OUT_IMM`, `OUT_TARGET` and `OUT_VALID` hold stable. S1 holds its contents, and `IN_READY` is low if S1 is full.
- Order is strictly FIFO. No result is dropped or duplicated.
- `SHAMT` = 2 with `MODE` = 0 reproduces the legacy branch offset ×4 sign-extend behaviour.

## Timing
- Reset (`RESET` high at a rising edge):
  - `v1`, `OUT_VALID` ← 0.
  - `imm1`, `pcinc1`, `OUT_IMM`, `OUT_TARGET` ← 0.
  - `IN_READY` is 0 while `RESET` is high and 1 in the first cycle after reset.
- Latency: an input accepted at edge N gives `OUT_VALID` = 1 after edge N+1, provided S2 is free.
- Throughput: one result per cycle while `OUT_READY` = 1.
- Capacity: 2 entries (S1 + S2). With `OUT_READY` held low, at most 2 inputs are accepted.
- Reset asserted mid-operation flushes both stages in one edge. In-flight results are lost and `OUT_VALID` = 0 after that edge.
- `OUT_*` are registered outputs. `IN_READY` is the only combinational output; its only path is from `OUT_READY`, `RESET` and internal state.

## Test plan
- Sign-extend ×4:
  - Stimulus: `OFFSET` = 8'hFE, `MODE` = 0, `SHAMT` = 2, `PC` = 32'h100.
  - Required: after 2 edges, `OUT_IMM` = 32'hFFFF_FFF8 and `OUT_TARGET` = 32'h0000_00FC.
- Zero-extend, no shift:
  - Stimulus: `OFFSET` = 8'hFE, `MODE` = 1, `SHAMT` = 0, `PC` = 0.
  - Required: `OUT_IMM` = 32'h0000_00FE, `OUT_TARGET` = 32'h0000_0102.
- Wrap-around:
  - Stimulus: `PC` = 32'hFFFF_FFF8, `OFFSET` = 8'h01, `MODE` = 0, `SHAMT` = 2.
  - Required: `OUT_IMM` = 32'h4, `OUT_TARGET` = 32'h0000_0000 (carry discarded). Also `SHAMT` = 3, `OFFSET` = 8'h80, `MODE` = 0 → `OUT_IMM` = 32'hFFFF_FC00.
- Backpressure:
  - Stimulus: 4 back-to-back inputs A–D with `OUT_READY` = 0 for 4 cycles, then 1.
  - Required: exactly A and B are accepted, and `IN_READY` = 0 once both stages are full. Outputs hold A stable while stalled. Results emerge in order A, B, C, D with no gaps once released.
- Streaming:
  - Stimulus: 16 random inputs with `IN_VALID` and `OUT_READY` both constantly 1.
  - Required: one valid output per cycle matching a reference model, 2-cycle latency.
- Reset mid-operation:
  - Stimulus: both stages full, then `RESET` pulsed for 1 cycle.
  - Required: after the edge, `OUT_VALID` = 0, `OUT_IMM` = `OUT_TARGET` = 0, and `IN_READY` = 1 in the following cycle. The next input produces a correct result with no stale data.
